hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32 core. It drives the stall and flush inputs of the fetch, decode, execute, memory and writeback pipeline registers, and the forwarding selects for the execute-stage ALU operands. It also runs a post-reset pipeline-clean sequence and a data-memory wait tracker with timeout, and keeps saturating stall and flush performance counters.

Parameters:
REG_AW, 6, register address width (matches RS1D/RS2D/RDD widths)
INIT_CYCLES, 4, cycles of forced flush after reset release (>=1)
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout is raised (>=1)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
RS1D, RS2D  in  REG_AW  decode-stage source registers
RS1E, RS2E, RDE  in  REG_AW  execute-stage source and destination registers
RDM, RDW  in  REG_AW  memory-stage and writeback-stage destination registers
RegWriteM, RegWriteW  in  1  register write enable in M and W
ResultSrcE  in  2  execute-stage result select; 2'b01 = load
PCSrcE  in  1  branch or jump taken, resolved in E
MemReqM  in  1  load or store active in M
MemReadyM  in  1  data memory completes the M access this cycle
ForwardAE, ForwardBE  out  2  00 register file, 10 ALUResultM, 01 ResultW
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (drives its clear input)
mem_timeout  out  1  sticky error flag
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- State machine: INIT, RUN, MEM_WAIT. Registers: state, init_cnt, wait_cnt, mem_timeout, stall_cnt, flush_cnt.
- Reset, on a posedge with rst_n=0: state=INIT, init_cnt=0, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. Reset taken mid-MEM_WAIT or mid-INIT behaves the same way.
- Control outputs are combinational from state and inputs.
- While rst_n=0, control outputs take their INIT values.
- INIT:
  - StallF=1, FlushD=FlushE=FlushW=1; all other stalls 0; forwards 00.
  - init_cnt increments each cycle.
  - Go to RUN on the posedge where init_cnt==INIT_CYCLES-1, so INIT lasts exactly INIT_CYCLES cycles.
  - Counters do not count in INIT.
- Forwarding (RUN and MEM_WAIT), for ForwardAE (same rule with RS2E for ForwardBE):
  - 10 if RegWriteM and RDM!=0 and RDM==RS1E.
  - Else 01 if RegWriteW and RDW!=0 and RDW==RS1E.
  - Else 00.
  - M has priority over W. Register x0 is never forwarded.
- mem_stall = MemReqM & ~MemReadyM.
- lw_stall = (ResultSrcE==2'b01) & (RDE!=0) & (RDE==RS1D | RDE==RS2D) & ~PCSrcE & ~mem_stall.
- RUN outputs:
  - mem_stall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. PCSrcE and lw_stall are ignored that cycle.
  - Else PCSrcE=1: FlushD=FlushE=1, no stalls.
  - Else lw_stall=1: StallF=StallD=1, FlushE=1.
  - Otherwise all 0.
- RUN transitions: mem_stall → MEM_WAIT with wait_cnt=1; else stay in RUN.
- MEM_WAIT:
  - Same outputs as mem_stall in RUN while MemReadyM=0.
  - On MemReadyM=1, outputs follow the RUN rules for that cycle and state returns to RUN, wait_cnt=0.
  - wait_cnt increments each stalled cycle and saturates.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set. It stays set until reset.
  - The pipeline stays stalled after timeout.
- Counters:
  - stall_cnt +1 every RUN or MEM_WAIT cycle with StallD=1.
  - flush_cnt +1 every cycle PCSrcE causes FlushD.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset then release: rst_n low 2 cycles, then high → StallF, FlushD, FlushE, FlushW high for exactly 4 cycles, then all 0; counters 0.
- Forwarding: RDM=5, RegWriteM=1, RDW=5, RegWriteW=1, RS1E=5, RS2E=0 → ForwardAE=10, ForwardBE=00; then drop RegWriteM → ForwardAE=01; then RDM=RDW=0 with RS1E=0 → 00.
- Load-use: ResultSrcE=01, RDE=7, RS2D=7 → StallF=StallD=FlushE=1 for one cycle, stall_cnt=1; repeat with PCSrcE=1 → FlushD=FlushE=1, no stall, flush_cnt=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF/D/E/M and FlushW high 3 cycles, release on the ready cycle, stall_cnt=3, state back to RUN.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → mem_timeout rises after the 4th stalled cycle and stays high after MemReadyM=1; clears only on rst_n=0.
- Counter saturation: CNT_W=3, 10 taken branches → flush_cnt=7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control, post-reset flush sequence, memory wait tracker and perf counters for the 5-stage core
module hazard_ctrl #(
    parameter int REG_AW      = 6,
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] RS1D,
    input  logic [REG_AW-1:0] RS2D,
    input  logic [REG_AW-1:0] RS1E,
    input  logic [REG_AW-1:0] RS2E,
    input  logic [REG_AW-1:0] RDE,
    input  logic [REG_AW-1:0] RDM,
    input  logic [REG_AW-1:0] RDW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] init_cnt, init_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          timeout_nxt;
    logic          stall_inc, flush_inc;
    logic          mem_stall, lw_stall, hold;
    logic [1:0]    fa_run, fb_run;

    assign mem_stall = MemReqM & ~MemReadyM;
    assign lw_stall  = (ResultSrcE == 2'b01) & (RDE != '0) & ((RDE == RS1D) | (RDE == RS2D))
                     & ~PCSrcE & ~mem_stall;
    // Once waiting, only the ready strobe releases the pipeline.
    assign hold      = (state == MEM_WAIT) ? ~MemReadyM : mem_stall;

    always_comb begin
        fa_run = 2'b00;
        if (RegWriteM && (RDM != '0) && (RDM == RS1E))
            fa_run = 2'b10;
        else if (RegWriteW && (RDW != '0) && (RDW == RS1E))
            fa_run = 2'b01;
        fb_run = 2'b00;
        if (RegWriteM && (RDM != '0) && (RDM == RS2E))
            fb_run = 2'b10;
        else if (RegWriteW && (RDW != '0) && (RDW == RS2E))
            fb_run = 2'b01;
    end

    always_comb begin
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        state_nxt   = state;
        init_nxt    = init_cnt;
        wait_nxt    = wait_cnt;
        timeout_nxt = mem_timeout;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst_n || state == INIT) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
            if (init_cnt == INIT_LAST) begin
                state_nxt = RUN;
                init_nxt  = '0;
            end else begin
                init_nxt  = init_cnt + IW'(1);
            end
        end else if (state == RUN || state == MEM_WAIT) begin
            ForwardAE = fa_run;
            ForwardBE = fb_run;
            if (hold) begin
                StallF    = 1'b1;
                StallD    = 1'b1;
                StallE    = 1'b1;
                StallM    = 1'b1;
                FlushW    = 1'b1;
                state_nxt = MEM_WAIT;
                if (state == RUN)
                    wait_nxt = WW'(1);
                else if (wait_cnt != WAIT_MAX)
                    wait_nxt = wait_cnt + WW'(1);
                if (wait_nxt == WAIT_MAX)
                    timeout_nxt = 1'b1;
            end else begin
                state_nxt = RUN;
                wait_nxt  = '0;
                if (PCSrcE) begin
                    FlushD    = 1'b1;
                    FlushE    = 1'b1;
                    flush_inc = 1'b1;
                end else if (lw_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            stall_inc = StallD;
        end else begin
            state_nxt = INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            init_cnt    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= timeout_nxt;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
